nmr_chip_cfg_axil_slave: RTL and testbench

NMR_CHIP_CFG_AXIL_SLAVE -- requirements
Module: nmr_chip_cfg_axil_slave

---
 rtl/nmr_cfg_pkg.sv | 40 ++++
 rtl/nmr_chip_cfg_axil_slave_if.sv | 39 +++
 rtl/nmr_cfg_shifter.sv | 118 +++++++++++
 rtl/nmr_chip_cfg_axil_slave.sv | 155 +++++++++++++++
 tb/tb_nmr_chip_cfg_axil_slave.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/nmr_cfg_pkg.sv
// nmr_cfg_pkg: shared definitions for the NMR chip configuration slave.
// Holds the register word indices, CTRL/STATUS bit positions, AXI response
// encodings and the serial shifter state enum, plus two small helpers.
// No ports (package).
package nmr_cfg_pkg;

   // Register word index = byte address bits [3:2]
   localparam logic [1:0] IDX_CTRL   = 2'd0;  // 0x00
   localparam logic [1:0] IDX_STATUS = 2'd1;  // 0x04
   localparam logic [1:0] IDX_TXDATA = 2'd2;  // 0x08
   localparam logic [1:0] IDX_RXDATA = 2'd3;  // 0x0C

   // Byte address bit that selects the 0x10-0x1C window
   localparam int ADDR_ERR_BIT = 4;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_CLKDIV_LSB = 8;
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } shift_state_t;

   function automatic logic [1:0] resp_for(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

   // True for addresses in the upper (0x10-0x1C) window
   function automatic logic is_upper_addr(input logic [4:0] addr);
      return addr[ADDR_ERR_BIT];
   endfunction

endpackage

// File: rtl/nmr_chip_cfg_axil_slave_if.sv
// nmr_chip_cfg_axil_slave_if: AXI4-Lite bus bundle (five channels, no clock).
// Modports: master drives addresses/data/valids/ready-for-response,
//           slave drives readies, responses and read data.
interface nmr_chip_cfg_axil_slave_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/nmr_cfg_shifter.sv
// nmr_cfg_shifter: 32-bit serial transfer engine for the NMR chip config port.
// Ports: clk, rst_n (async active-low); start (1-cycle request, ignored while
//        busy), clkdiv (half-period = clkdiv+1 clk cycles, latched at start),
//        txdata (latched at start); busy, done (1-cycle pulse at end),
//        rxdata (bits shifted in MSB first); cs_n, sclk, sdi out, sdo in.
// Sequence: IDLE -> SETUP (one half-period, cs_n low) -> SHIFT (32 sclk pulses)
//           -> HOLD (final low half-period) -> IDLE.
module nmr_cfg_shifter
   import nmr_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  clkdiv,
   input  logic [31:0] txdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rxdata,
   output logic        cs_n,
   output logic        sclk,
   output logic        sdi,
   input  logic        sdo
);
   shift_state_t state_reg;
   logic [7:0]   div_reg;
   logic [7:0]   cnt_reg;
   logic [4:0]   bit_reg;
   logic [31:0]  sh_reg;
   logic [31:0]  rx_reg;
   logic         busy_reg, done_reg, cs_n_reg, sclk_reg, sdi_reg;
   logic         half_end;

   assign half_end = (cnt_reg == div_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         div_reg   <= '0;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         sh_reg    <= '0;
         rx_reg    <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         cs_n_reg  <= 1'b1;
         sclk_reg  <= 1'b0;
         sdi_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg <= ST_SETUP;
                  div_reg   <= clkdiv;
                  cnt_reg   <= '0;
                  bit_reg   <= '0;
                  busy_reg  <= 1'b1;
                  cs_n_reg  <= 1'b0;
                  sdi_reg   <= txdata[31];
                  sh_reg    <= {txdata[30:0], 1'b0};
               end
            end
            ST_SETUP: begin
               if (half_end) begin
                  // First rising edge; sdo is captured as sclk goes high
                  cnt_reg   <= '0;
                  state_reg <= ST_SHIFT;
                  sclk_reg  <= 1'b1;
                  rx_reg    <= {rx_reg[30:0], sdo};
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (half_end) begin
                  cnt_reg <= '0;
                  if (sclk_reg) begin
                     // Falling edge: advance sdi, or leave for HOLD after bit 0
                     sclk_reg <= 1'b0;
                     if (bit_reg == 5'd31) begin
                        state_reg <= ST_HOLD;
                     end else begin
                        sdi_reg <= sh_reg[31];
                        sh_reg  <= {sh_reg[30:0], 1'b0};
                     end
                  end else begin
                     sclk_reg <= 1'b1;
                     rx_reg   <= {rx_reg[30:0], sdo};
                     bit_reg  <= bit_reg + 5'd1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            ST_HOLD: begin
               if (half_end) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  cs_n_reg  <= 1'b1;
                  sdi_reg   <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign rxdata = rx_reg;
   assign cs_n   = cs_n_reg;
   assign sclk   = sclk_reg;
   assign sdi    = sdi_reg;
endmodule

// File: rtl/nmr_chip_cfg_axil_slave.sv
// nmr_chip_cfg_axil_slave: AXI4-Lite register slave driving the NMR chip
// serial configuration port through nmr_cfg_shifter.
// Ports: ACLK, ARESETN (async active-low); s_axi (AXI4-Lite slave modport);
//        cfg_cs_n, cfg_sclk, cfg_sdi out; cfg_sdo in.
// Map: 0x00 CTRL (bit0 START self-clearing, 15:8 CLKDIV), 0x04 STATUS
//      (bit0 BUSY, bit1 DONE sticky, W1C), 0x08 TXDATA, 0x0C RXDATA.
// Build option: NMR_CFG_SLVERR_EN makes 0x10-0x1C answer SLVERR with no
//      effect; without it those addresses alias 0x00-0x0C.
module nmr_chip_cfg_axil_slave
   import nmr_cfg_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   nmr_chip_cfg_axil_slave_if.slave    s_axi,
   output logic                        cfg_cs_n,
   output logic                        cfg_sclk,
   output logic                        cfg_sdi,
   input  logic                        cfg_sdo
);
   logic                          awready_reg, bvalid_reg, arready_reg, rvalid_reg;
   logic [1:0]                    bresp_reg, rresp_reg;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg, txdata_reg, rd_word, wmask;
   logic [7:0]                    clkdiv_reg, start_clkdiv;
   logic                          done_reg;
   logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic                          wr_fire, wr_err, wr_ok, rd_fire, rd_err, start;
   logic                          busy, done_pulse;
   logic [31:0]                   rxdata;
   logic                          unused_ok;

   assign wr_addr = s_axi.awaddr;
   assign rd_addr = s_axi.araddr;
   assign wr_fire = awready_reg && s_axi.awvalid && s_axi.wvalid;
   assign rd_fire = arready_reg && s_axi.arvalid;

`ifdef NMR_CFG_SLVERR_EN
   assign wr_err = is_upper_addr(wr_addr);
   assign rd_err = is_upper_addr(rd_addr);
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

   assign wr_ok = wr_fire && !wr_err;
   assign unused_ok = ^{s_axi.awprot, s_axi.arprot, wr_addr, rd_addr};

   // Expand byte strobes to a bit mask for the TXDATA merge
   for (genvar gi = 0; gi < C_S_AXI_DATA_WIDTH / 8; gi++) begin : g_wmask
      assign wmask[8*gi +: 8] = {8{s_axi.wstrb[gi]}};
   end

   // A START write that also updates CLKDIV uses the new divider immediately
   assign start = wr_ok && (wr_addr[3:2] == IDX_CTRL) && s_axi.wstrb[0]
                  && s_axi.wdata[CTRL_START_BIT];
   assign start_clkdiv = (wr_ok && (wr_addr[3:2] == IDX_CTRL) && s_axi.wstrb[1])
                         ? s_axi.wdata[CTRL_CLKDIV_LSB +: 8] : clkdiv_reg;

   // Write channel: ready pulses for one cycle, response held until accepted
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awready_reg <= 1'b0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
      end else begin
         awready_reg <= !awready_reg && s_axi.awvalid && s_axi.wvalid && !bvalid_reg;
         if (wr_fire) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= resp_for(wr_err);
         end else if (bvalid_reg && s_axi.bready) begin
            bvalid_reg <= 1'b0;
         end
      end
   end

   // Register file; STATUS/RXDATA writes only act through the DONE clear
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         clkdiv_reg <= '0;
         txdata_reg <= '0;
         done_reg   <= 1'b0;
      end else begin
         if (wr_ok && (wr_addr[3:2] == IDX_CTRL) && s_axi.wstrb[1])
            clkdiv_reg <= s_axi.wdata[CTRL_CLKDIV_LSB +: 8];
         if (wr_ok && (wr_addr[3:2] == IDX_TXDATA))
            txdata_reg <= (txdata_reg & ~wmask) | (s_axi.wdata & wmask);
         // A completing transfer wins over a simultaneous clear
         if (done_pulse)
            done_reg <= 1'b1;
         else if (wr_ok && (wr_addr[3:2] == IDX_STATUS) && s_axi.wstrb[0]
                  && s_axi.wdata[STATUS_DONE_BIT])
            done_reg <= 1'b0;
      end
   end

   always_comb begin
      rd_word = '0;
      case (rd_addr[3:2])
         IDX_CTRL:   rd_word[CTRL_CLKDIV_LSB +: 8] = clkdiv_reg;
         IDX_STATUS: begin
            rd_word[STATUS_BUSY_BIT] = busy;
            rd_word[STATUS_DONE_BIT] = done_reg;
         end
         IDX_TXDATA: rd_word = txdata_reg;
         IDX_RXDATA: rd_word = rxdata;
         default:    rd_word = '0;
      endcase
   end

   // Read channel: data captured at the handshake, so a same-cycle write
   // to the same register is not yet visible
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rresp_reg   <= RESP_OKAY;
         rdata_reg   <= '0;
      end else begin
         arready_reg <= !arready_reg && s_axi.arvalid && !rvalid_reg;
         if (rd_fire) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= resp_for(rd_err);
            rdata_reg  <= rd_err ? '0 : rd_word;
         end else if (rvalid_reg && s_axi.rready) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

   assign s_axi.awready = awready_reg;
   assign s_axi.wready  = awready_reg;
   assign s_axi.bvalid  = bvalid_reg;
   assign s_axi.bresp   = bresp_reg;
   assign s_axi.arready = arready_reg;
   assign s_axi.rvalid  = rvalid_reg;
   assign s_axi.rresp   = rresp_reg;
   assign s_axi.rdata   = rdata_reg;

   nmr_cfg_shifter u_shifter (
      .clk    (ACLK),
      .rst_n  (ARESETN),
      .start  (start),
      .clkdiv (start_clkdiv),
      .txdata (txdata_reg),
      .busy   (busy),
      .done   (done_pulse),
      .rxdata (rxdata),
      .cs_n   (cfg_cs_n),
      .sclk   (cfg_sclk),
      .sdi    (cfg_sdi),
      .sdo    (cfg_sdo)
   );
endmodule

// File: tb/tb_nmr_chip_cfg_axil_slave.sv
// tb_nmr_chip_cfg_axil_slave: directed self-checking bench for the NMR chip
// configuration AXI4-Lite slave. cfg_sdo is looped back from cfg_sdi.
// Honours NMR_CFG_SLVERR_EN for the 0x10-0x1C window expectations.
module tb_nmr_chip_cfg_axil_slave;
   logic ACLK = 1'b0;
   logic ARESETN;
   logic cfg_cs_n, cfg_sclk, cfg_sdi, cfg_sdo;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int rise_q[$];
   logic sclk_prev = 1'b0;

   nmr_chip_cfg_axil_slave_if bus ();

   nmr_chip_cfg_axil_slave dut (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .s_axi    (bus),
      .cfg_cs_n (cfg_cs_n),
      .cfg_sclk (cfg_sclk),
      .cfg_sdi  (cfg_sdi),
      .cfg_sdo  (cfg_sdo)
   );

   assign cfg_sdo = cfg_sdi;

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) cyc <= cyc + 1;

   // Record the cycle of every sclk rising edge
   always @(negedge ACLK) begin
      if (cfg_sclk && !sclk_prev) rise_q.push_back(cyc);
      sclk_prev <= cfg_sclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      logic ok;
      bus.awaddr = a; bus.awprot = 3'd0; bus.wdata = d; bus.wstrb = s;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge ACLK);
         ok = bus.awready & bus.wready;
      end
      if (!ok) check("aw_w_ready_timeout", {31'd0, ok}, 32'd1);
      @(posedge ACLK); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge ACLK);
         ok = bus.bvalid;
      end
      if (!ok) check("bvalid_timeout", {31'd0, ok}, 32'd1);
      resp = bus.bresp;
      @(posedge ACLK); #1;
      bus.bready = 1'b0;
      $display("WR addr=0x%02h data=0x%08h strb=%b bresp=%b", a, d, s, resp);
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      logic ok;
      bus.araddr = a; bus.arprot = 3'd0; bus.arvalid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge ACLK);
         ok = bus.arready;
      end
      if (!ok) check("arready_timeout", {31'd0, ok}, 32'd1);
      @(posedge ACLK); #1;
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge ACLK);
         ok = bus.rvalid;
      end
      if (!ok) check("rvalid_timeout", {31'd0, ok}, 32'd1);
      d = bus.rdata;
      resp = bus.rresp;
      @(posedge ACLK); #1;
      bus.rready = 1'b0;
      $display("RD addr=0x%02h data=0x%08h rresp=%b", a, d, resp);
   endtask

   initial begin
      logic [31:0] rd, rd2;
      logic [1:0]  br, rr, rr2;
      logic        fin;
      int          base, bad;

      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      ARESETN = 1'b0;
      repeat (3) @(negedge ACLK);

      // Reset state
      check("rst_awready", {31'd0, bus.awready}, 32'd0);
      check("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
      check("rst_arready", {31'd0, bus.arready}, 32'd0);
      check("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
      check("rst_resp",    {28'd0, bus.bresp, bus.rresp}, 32'd0);
      check("rst_rdata",   bus.rdata, 32'd0);
      check("rst_pins",    {29'd0, cfg_cs_n, cfg_sclk, cfg_sdi}, 32'd4);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);

      // Single byte lane after reset
      axi_write(5'h08, 32'hFFFF_FFFF, 4'b0010, br);
      check("strb_bresp", {30'd0, br}, 32'd0);
      axi_read(5'h08, rd, rr);
      check("strb_rdata", rd, 32'h0000_FF00);

      // Full-word write/read of TXDATA
      axi_write(5'h08, 32'hA5A5_0001, 4'hF, br);
      axi_read(5'h08, rd, rr);
      check("tx_rdata", rd, 32'hA5A5_0001);
      check("tx_rresp", {30'd0, rr}, 32'd0);

      // Read-only RXDATA ignores writes, still OKAY
      axi_write(5'h0C, 32'h1234_5678, 4'hF, br);
      check("ro_bresp", {30'd0, br}, 32'd0);
      axi_read(5'h0C, rd, rr);
      check("ro_rxdata", rd, 32'd0);
      axi_read(5'h04, rd, rr);
      check("idle_status", rd, 32'd0);

      // Simultaneous read and write of TXDATA: read sees the old value
      fork
         axi_write(5'h08, 32'h8000_0001, 4'hF, br);
         axi_read(5'h08, rd2, rr2);
      join
      check("rw_same_old", rd2, 32'hA5A5_0001);
      axi_read(5'h08, rd, rr);
      check("rw_same_new", rd, 32'h8000_0001);

      // Transfer with CLKDIV=1
      base = rise_q.size();
      axi_write(5'h00, 32'h0000_0101, 4'hF, br);
      axi_read(5'h04, rd, rr);
      check("busy_status", rd, 32'h0000_0001);
      axi_write(5'h00, 32'h0000_0101, 4'hF, br);   // ignored START
      axi_write(5'h08, 32'h0000_0000, 4'hF, br);   // no effect on transfer
      fin = 1'b0;
      for (int n = 0; n < 2000 && !fin; n++) begin
         @(negedge ACLK);
         fin = cfg_cs_n;
      end
      check("xfer_end_timeout", {31'd0, fin}, 32'd1);
      repeat (30) @(negedge ACLK);
      check("sclk_pulses", rise_q.size() - base, 32'd32);
      bad = 0;
      for (int i = base + 1; i < rise_q.size(); i++)
         if (rise_q[i] - rise_q[i-1] != 4) bad++;
      check("sclk_period_bad", bad, 32'd0);
      axi_read(5'h0C, rd, rr);
      check("rx_loopback", rd, 32'h8000_0001);
      axi_read(5'h04, rd, rr);
      check("done_status", rd, 32'h0000_0002);
      axi_read(5'h00, rd, rr);
      check("ctrl_selfclr", rd, 32'h0000_0100);
      axi_write(5'h04, 32'h0000_0002, 4'hF, br);
      axi_read(5'h04, rd, rr);
      check("done_clear", rd, 32'd0);

      // Reset in the middle of a transfer
      axi_write(5'h08, 32'hDEAD_BEEF, 4'hF, br);
      base = rise_q.size();
      axi_write(5'h00, 32'h0000_0001, 4'hF, br);
      fin = 1'b0;
      for (int n = 0; n < 500 && !fin; n++) begin
         @(negedge ACLK);
         fin = (rise_q.size() - base >= 10);
      end
      check("bit10_timeout", {31'd0, fin}, 32'd1);
      ARESETN = 1'b0;
      #1;
      check("abort_pins", {29'd0, cfg_cs_n, cfg_sclk, cfg_sdi}, 32'd4);
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);
      axi_read(5'h04, rd, rr);
      check("abort_status", rd, 32'd0);
      axi_read(5'h0C, rd, rr);
      check("abort_rxdata", rd, 32'd0);
      axi_read(5'h08, rd, rr);
      check("abort_txdata", rd, 32'd0);

      // Upper address window
      axi_write(5'h00, 32'h0000_2300, 4'hF, br);
      axi_read(5'h10, rd, rr);
      axi_write(5'h18, 32'h0000_0055, 4'hF, br);
      axi_read(5'h08, rd2, rr2);
`ifdef NMR_CFG_SLVERR_EN
      check("hi_rresp", {30'd0, rr}, 32'd2);
      check("hi_rdata", rd, 32'd0);
      check("hi_bresp", {30'd0, br}, 32'd2);
      check("hi_nowrite", rd2, 32'd0);
`else
      check("hi_rresp", {30'd0, rr}, 32'd0);
      check("hi_rdata", rd, 32'h0000_2300);
      check("hi_bresp", {30'd0, br}, 32'd0);
      check("hi_alias_wr", rd2, 32'h0000_0055);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
